// File: rtl/top_fdct_mul_pkg.sv
// ---------------------------------------------------------------------------
// top_fdct_mul_pkg
// Shared widths and helpers for the fdct shared-multiplier arbiter.
//   A_W / B_W / P_W : signed multiplicand, unsigned multiplier, signed product
//   MAX_REQ / IDX_W : upper bound on requester count and index width used by
//                     the round-robin pick function
//   rr_pick()       : (mask, ptr, n) -> {found, idx}, first set bit of mask
//                     scanning ptr, ptr+1, ... modulo n
// ---------------------------------------------------------------------------
package top_fdct_mul_pkg;

  localparam int A_W = 16;
  localparam int B_W = 13;
  localparam int P_W = 29;

  localparam int MAX_REQ = 32;
  localparam int IDX_W   = 5;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] mask,
                                       input logic [IDX_W-1:0]   ptr,
                                       input int                 n);
    rr_pick_t       res;
    logic [IDX_W:0] pos;
    res = '0;
    // Scan from the farthest offset back to the nearest so that the
    // candidate closest to ptr is the one left standing.
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        pos = {1'b0, ptr} + (IDX_W + 1)'(k);
        if (pos >= (IDX_W + 1)'(n)) pos = pos - (IDX_W + 1)'(n);
        if (mask[pos[IDX_W-1:0]]) begin
          res.found = 1'b1;
          res.idx   = pos[IDX_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/top_fdct_mul_arb_fifo.sv
// ---------------------------------------------------------------------------
// top_fdct_mul_arb_fifo
// Synchronous first-word-fall-through FIFO holding {product, id} results.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   push       : write push_data (ignored only if full and not popping)
//   push_data  : WIDTH-bit entry
//   pop        : consume the head entry (ignored when empty)
//   pop_data   : current head entry, valid while count != 0
//   count      : number of stored entries, 0..DEPTH
// Push and pop in the same cycle are both honoured.
// ---------------------------------------------------------------------------
module top_fdct_mul_arb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 31
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != CW'(DEPTH)) || do_pop);

  // NOTE: storage carries no reset; only the pointers and count decide what
  // is valid, so clearing the array would just cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign count    = cnt;

endmodule

// File: rtl/top_fdct_mul_arbiter.sv
// ---------------------------------------------------------------------------
// top_fdct_mul_arbiter
// Shares one 16s x 13u -> 29s multiplier between N_REQ fdct requesters.
// Round-robin grant, one operand pair per cycle into a MUL_STAGES-deep
// product pipeline, results returned in issue order through an output FIFO
// tagged with the issuing requester's index.
//   ap_clk, ap_rst : rising-edge clock, synchronous active-high reset
//   req_valid      : per-requester operand valid
//   req_a          : signed multiplicands, slice i = [16*i +: 16]
//   req_b          : unsigned multipliers, slice i = [13*i +: 13]
//   req_ready      : one-hot grant, transfer on valid & ready
//   res_valid      : result available at FIFO head
//   res_ready      : consumer accepts the head result
//   res_p, res_id  : signed product and issuing requester index
//   busy           : anything in the pipeline or the FIFO
// ---------------------------------------------------------------------------
module top_fdct_mul_arbiter
  import top_fdct_mul_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int MUL_STAGES = 2,
  parameter int OUT_DEPTH  = 4,
  parameter int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*A_W-1:0]    req_a,
  input  logic [N_REQ*B_W-1:0]    req_b,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [P_W-1:0]   res_p,
  output logic [ID_W-1:0]         res_id,
  output logic                    busy
);

  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int E_W   = P_W + ID_W;

  // Arbiter and pipeline state
  logic [ID_W-1:0]        ptr;
  logic [MUL_STAGES-1:0]  s_v;
  logic signed [P_W-1:0]  s_p  [MUL_STAGES];
  logic [ID_W-1:0]        s_id [MUL_STAGES];

  // Grant path
  rr_pick_t               pick;
  logic                   credit_ok;
  logic [N_REQ-1:0]       gnt_oh;
  logic [ID_W-1:0]        gnt_id;
  logic                   handshake;

  // Datapath
  logic [A_W-1:0]         sel_a;
  logic [B_W-1:0]         sel_b;
  logic signed [P_W-1:0]  a_ext;
  logic signed [P_W-1:0]  b_ext;
  logic signed [P_W-1:0]  prod;

  // FIFO side
  logic [CNT_W-1:0]       fifo_count;
  logic [E_W-1:0]         head;
  logic                   pop;

  // Credit looks only at registered occupancy: a pop this cycle does not
  // free a slot until the next one, so res_ready never reaches req_ready.
  always_comb begin
    int occ;
    // NOTE: every variable written here gets a value before any condition,
    // which keeps the block purely combinational (no inferred latch).
    occ = int'(fifo_count);
    for (int k = 0; k < MUL_STAGES; k++) occ = occ + int'(s_v[k]);
    credit_ok = (occ < OUT_DEPTH);
  end

  assign pick   = rr_pick(MAX_REQ'(req_valid), IDX_W'(ptr), N_REQ);
  assign gnt_id = ID_W'(pick.idx);

  always_comb begin
    gnt_oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt_oh[i] = !ap_rst && credit_ok && pick.found && (pick.idx == IDX_W'(i));
    end
  end

  assign req_ready = gnt_oh;
  assign handshake = |(req_valid & gnt_oh);

  // Operand select for the granted requester
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_id == ID_W'(i)) begin
        sel_a = req_a[A_W*i +: A_W];
        sel_b = req_b[B_W*i +: B_W];
      end
    end
  end

  // b is zero-extended so the multiply stays signed x non-negative; the
  // product fits 29 bits exactly, so truncation to P_W loses nothing.
  assign a_ext = {{(P_W - A_W){sel_a[A_W-1]}}, sel_a};
  assign b_ext = {{(P_W - B_W){1'b0}}, sel_b};
  assign prod  = a_ext * b_ext;

  // Control: pointer and stage valids
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      ptr <= '0;
      s_v <= '0;
    end else begin
      if (handshake) ptr <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
      s_v[0] <= handshake;
      for (int k = 1; k < MUL_STAGES; k++) s_v[k] <= s_v[k-1];
    end
  end

  // Data: first register captures the product directly (DSP MREG/PREG),
  // later stages just delay product and id alongside the valid bits.
  always_ff @(posedge ap_clk) begin
    s_p[0]  <= prod;
    s_id[0] <= gnt_id;
    for (int k = 1; k < MUL_STAGES; k++) begin
      s_p[k]  <= s_p[k-1];
      s_id[k] <= s_id[k-1];
    end
  end

  assign pop = res_valid && res_ready;

  top_fdct_mul_arb_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (E_W)
  ) u_fifo (
    .clk       (ap_clk),
    .rst       (ap_rst),
    .push      (s_v[MUL_STAGES-1]),
    .push_data ({s_p[MUL_STAGES-1], s_id[MUL_STAGES-1]}),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count)
  );

  // Head fields are forced to zero while empty so reset shows clean outputs.
  assign res_valid = (fifo_count != '0);
  assign res_p     = res_valid ? head[ID_W +: P_W] : '0;
  assign res_id    = res_valid ? head[ID_W-1:0]    : '0;
  assign busy      = (|s_v) || res_valid;

endmodule

// File: tb/tb_top_fdct_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_top_fdct_mul_arbiter
// Directed bench for the shared fdct multiplier arbiter: reset, single
// products at the arithmetic boundaries, round-robin throughput, fairness,
// backpressure and reset mid-flight. Inputs change 1 ns after the rising
// edge, outputs are checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_top_fdct_mul_arbiter;

  localparam int N_REQ      = 4;
  localparam int MUL_STAGES = 2;
  localparam int OUT_DEPTH  = 4;
  localparam int ID_W       = 2;

  logic                  ap_clk = 1'b0;
  logic                  ap_rst;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*16-1:0]   req_a;
  logic [N_REQ*13-1:0]   req_b;
  logic [N_REQ-1:0]      req_ready;
  logic                  res_valid;
  logic                  res_ready;
  logic [28:0]           res_p;
  logic [ID_W-1:0]       res_id;
  logic                  busy;

  int tests_run    = 0;
  int tests_failed = 0;

  // Per-requester operands for the multi-requester scenarios
  logic signed [15:0] tab_a [N_REQ] = '{16'sd100, -16'sd7, 16'sd2000, 16'sh8000};
  logic [12:0]        tab_b [N_REQ] = '{13'd3, 13'd11, 13'd4000, 13'd1};
  logic signed [28:0] tab_p [N_REQ] = '{29'sd300, -29'sd77, 29'sd8000000, -29'sd32768};

  int          id_q [$];
  logic [28:0] p_q  [$];
  int          grant_q [$];

  always #5 ap_clk = ~ap_clk;

  top_fdct_mul_arbiter #(
    .N_REQ      (N_REQ),
    .MUL_STAGES (MUL_STAGES),
    .OUT_DEPTH  (OUT_DEPTH)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_p     (res_p),
    .res_id    (res_id),
    .busy      (busy)
  );

  // Log grants and popped results; inputs are stable from posedge+1 to the
  // next posedge, so the falling edge sees exactly what the edge will take.
  always @(negedge ap_clk) begin
    if (!ap_rst) begin
      for (int i = 0; i < N_REQ; i++)
        if (req_valid[i] && req_ready[i]) grant_q.push_back(i);
      if (res_valid && res_ready) begin
        id_q.push_back(int'(res_id));
        p_q.push_back(res_p);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic to_mid();
    @(negedge ap_clk);
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [12:0] b);
    req_a[16*i +: 16] = a;
    req_b[13*i +: 13] = b;
  endtask

  task automatic load_table();
    for (int i = 0; i < N_REQ; i++) set_req(i, tab_a[i], tab_b[i]);
  endtask

  task automatic clear_logs();
    id_q.delete();
    p_q.delete();
    grant_q.delete();
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      to_mid();
      if (!busy && !res_valid) done = 1'b1;
      else next_cycle();
    end
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL %s_drain: busy=%0b after 40 cycles, required 0", name, busy);
    end
    next_cycle();
  endtask

  // One product from one requester, checking grant, latency and value.
  task automatic run_single(input int idx, input logic signed [15:0] a,
                            input logic [12:0] b, input logic signed [28:0] exp_p,
                            input string name);
    logic [N_REQ-1:0] exp_rdy;
    clear_logs();
    exp_rdy      = '0;
    exp_rdy[idx] = 1'b1;
    res_ready    = 1'b1;
    set_req(idx, a, b);
    req_valid    = exp_rdy;
    to_mid();
    tests_run++;
    if (req_ready !== exp_rdy) begin
      tests_failed++;
      $display("FAIL %s_grant: req_ready=%b, required %b", name, req_ready, exp_rdy);
    end
    next_cycle();
    req_valid = '0;
    for (int k = 1; k <= MUL_STAGES; k++) begin
      to_mid();
      tests_run++;
      if (res_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s_early: res_valid=%b %0d cycles after issue, required 0", name, res_valid, k);
      end
      next_cycle();
    end
    to_mid();
    tests_run++;
    if (res_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_latency: res_valid=%b at latency %0d, required 1", name, res_valid, MUL_STAGES + 1);
    end
    tests_run++;
    if (res_p !== exp_p) begin
      tests_failed++;
      $display("FAIL %s_p: res_p=%0d, required %0d", name, $signed(res_p), exp_p);
    end
    tests_run++;
    if (res_id !== ID_W'(idx)) begin
      tests_failed++;
      $display("FAIL %s_id: res_id=%0d, required %0d", name, res_id, idx);
    end
    next_cycle();
    to_mid();
    tests_run++;
    if (res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_pop: res_valid=%b after pop, required 0", name, res_valid);
    end
    next_cycle();
    tests_run++;
    if (id_q.size() != 1) begin
      tests_failed++;
      $display("FAIL %s_count: %0d results, required 1", name, id_q.size());
    end
  endtask

  task automatic test_reset();
    ap_rst    = 1'b1;
    res_ready = 1'b1;
    load_table();
    req_valid = '1;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      to_mid();
      tests_run++;
      if (req_ready !== '0) begin
        tests_failed++;
        $display("FAIL reset_ready: req_ready=%b during reset, required 0000", req_ready);
      end
    end
    tests_run++;
    if ({res_valid, busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_flags: res_valid=%b busy=%b, required 0 0", res_valid, busy);
    end
    tests_run++;
    if (res_p !== '0 || res_id !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: res_p=%0d res_id=%0d, required 0 0", res_p, res_id);
    end
    next_cycle();
    req_valid = '0;
    ap_rst    = 1'b0;
    next_cycle();
  endtask

  task automatic test_single();
    run_single(0, 16'sh8000, 13'd8191, -29'sd268402688, "single_min");
  endtask

  task automatic test_boundaries();
    run_single(1, 16'sd32767, 13'd8191, 29'sd268394497, "bound_max");
    run_single(2, -16'sd1,    13'd1,    -29'sd1,         "bound_neg1");
    run_single(3, 16'sd0,     13'd8191, 29'sd0,          "bound_zero_a");
    run_single(0, 16'sd12345, 13'd0,    29'sd0,          "bound_zero_b");
    run_single(2, 16'sd1234,  13'd5678, 29'sd7006652,    "bound_mid");
    run_single(3, -16'sd2,    13'd4096, -29'sd8192,      "bound_neg2");
  endtask

  // Pointer is at 0 here: all four valid should grant 0,1,2,3 every cycle.
  task automatic test_round_robin();
    logic [N_REQ-1:0] exp_rdy;
    clear_logs();
    res_ready = 1'b1;
    load_table();
    req_valid = '1;
    for (int c = 0; c < 12; c++) begin
      to_mid();
      exp_rdy = N_REQ'(1 << (c % N_REQ));
      tests_run++;
      if (req_ready !== exp_rdy) begin
        tests_failed++;
        $display("FAIL rr_grant[%0d]: req_ready=%b, required %b", c, req_ready, exp_rdy);
      end
      if (c > 0) begin
        tests_run++;
        if (busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL rr_busy[%0d]: busy=%b, required 1", c, busy);
        end
      end
      next_cycle();
    end
    req_valid = '0;
    wait_idle("rr");
    tests_run++;
    if (id_q.size() != 12) begin
      tests_failed++;
      $display("FAIL rr_count: %0d results, required 12", id_q.size());
    end else begin
      for (int c = 0; c < 12; c++) begin
        tests_run++;
        if (id_q[c] != (c % N_REQ) || p_q[c] !== tab_p[c % N_REQ]) begin
          tests_failed++;
          $display("FAIL rr_result[%0d]: id=%0d p=%0d, required id=%0d p=%0d",
                   c, id_q[c], $signed(p_q[c]), c % N_REQ, tab_p[c % N_REQ]);
        end
      end
    end
  endtask

  task automatic test_fairness();
    int exp_ids [7] = '{3, 1, 2, 3, 0, 1, 2};
    int waits;
    bit got2;
    run_single(1, 16'sd5, 13'd5, 29'sd25, "fair_setup");
    clear_logs();
    load_table();
    req_valid = 4'b1010;
    to_mid();
    tests_run++;
    if (req_ready !== 4'b1000) begin
      tests_failed++;
      $display("FAIL fair_after1: req_ready=%b, required 1000", req_ready);
    end
    next_cycle();
    req_valid = 4'b0010;
    to_mid();
    tests_run++;
    if (req_ready !== 4'b0010) begin
      tests_failed++;
      $display("FAIL fair_then1: req_ready=%b, required 0010", req_ready);
    end
    next_cycle();
    req_valid = 4'b0100;
    to_mid();
    tests_run++;
    if (req_ready !== 4'b0100) begin
      tests_failed++;
      $display("FAIL fair_lone2: req_ready=%b, required 0100", req_ready);
    end
    next_cycle();
    // Pointer now sits at 3: req2 must let 3, 0 and 1 go first.
    req_valid = '1;
    waits     = 0;
    got2      = 1'b0;
    for (int c = 0; c < 8 && !got2; c++) begin
      to_mid();
      if (req_ready[2]) got2 = 1'b1;
      else if (req_ready != '0) waits++;
      next_cycle();
    end
    req_valid = '0;
    tests_run++;
    if (!got2 || waits != N_REQ - 1) begin
      tests_failed++;
      $display("FAIL fair_wait: req2 granted=%b after %0d grants, required 1 after %0d",
               got2, waits, N_REQ - 1);
    end
    wait_idle("fair");
    tests_run++;
    if (id_q.size() != 7) begin
      tests_failed++;
      $display("FAIL fair_count: %0d results, required 7", id_q.size());
    end else begin
      for (int c = 0; c < 7; c++) begin
        tests_run++;
        if (id_q[c] != exp_ids[c] || p_q[c] !== tab_p[exp_ids[c]]) begin
          tests_failed++;
          $display("FAIL fair_result[%0d]: id=%0d p=%0d, required id=%0d p=%0d",
                   c, id_q[c], $signed(p_q[c]), exp_ids[c], tab_p[exp_ids[c]]);
        end
      end
    end
  endtask

  // Pointer at 3 and consumer stalled: four grants 3,0,1,2 fill the credit.
  task automatic test_backpressure();
    int exp_ids [4] = '{3, 0, 1, 2};
    clear_logs();
    res_ready = 1'b0;
    load_table();
    req_valid = '1;
    for (int c = 0; c < 10; c++) next_cycle();
    to_mid();
    tests_run++;
    if (req_ready !== '0) begin
      tests_failed++;
      $display("FAIL bp_ready: req_ready=%b with full credit, required 0000", req_ready);
    end
    tests_run++;
    if (grant_q.size() != OUT_DEPTH) begin
      tests_failed++;
      $display("FAIL bp_grants: %0d handshakes, required %0d", grant_q.size(), OUT_DEPTH);
    end
    tests_run++;
    if ({res_valid, busy} !== 2'b11) begin
      tests_failed++;
      $display("FAIL bp_flags: res_valid=%b busy=%b, required 1 1", res_valid, busy);
    end
    next_cycle();
    req_valid = '0;
    res_ready = 1'b1;
    wait_idle("bp");
    tests_run++;
    if (id_q.size() != OUT_DEPTH) begin
      tests_failed++;
      $display("FAIL bp_count: %0d results drained, required %0d", id_q.size(), OUT_DEPTH);
    end else begin
      for (int c = 0; c < OUT_DEPTH; c++) begin
        tests_run++;
        if (id_q[c] != exp_ids[c] || p_q[c] !== tab_p[exp_ids[c]]) begin
          tests_failed++;
          $display("FAIL bp_result[%0d]: id=%0d p=%0d, required id=%0d p=%0d",
                   c, id_q[c], $signed(p_q[c]), exp_ids[c], tab_p[exp_ids[c]]);
        end
      end
    end
  endtask

  // Three issues with res_ready low leave one result in the FIFO and two in
  // the pipeline; a one-cycle reset must throw all of it away.
  task automatic test_reset_midflight();
    logic [N_REQ-1:0] exp_rdy [3] = '{4'b1000, 4'b0001, 4'b0010};
    clear_logs();
    res_ready = 1'b0;
    load_table();
    req_valid = '1;
    for (int c = 0; c < 3; c++) begin
      to_mid();
      tests_run++;
      if (req_ready !== exp_rdy[c]) begin
        tests_failed++;
        $display("FAIL mid_fill[%0d]: req_ready=%b, required %b", c, req_ready, exp_rdy[c]);
      end
      next_cycle();
    end
    ap_rst = 1'b1;
    to_mid();
    tests_run++;
    if (req_ready !== '0 || res_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_inreset: req_ready=%b res_valid=%b, required 0000 1", req_ready, res_valid);
    end
    next_cycle();
    ap_rst    = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    to_mid();
    tests_run++;
    if ({res_valid, busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL mid_cleared: res_valid=%b busy=%b, required 0 0", res_valid, busy);
    end
    for (int c = 0; c < 6; c++) next_cycle();
    tests_run++;
    if (id_q.size() != 0) begin
      tests_failed++;
      $display("FAIL mid_stale: %0d results after reset, required 0", id_q.size());
    end
    req_valid = '1;
    to_mid();
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL mid_restart: req_ready=%b, required 0001", req_ready);
    end
    next_cycle();
    req_valid = '0;
    wait_idle("mid");
    tests_run++;
    if (id_q.size() != 1 || id_q[0] != 0 || p_q[0] !== tab_p[0]) begin
      tests_failed++;
      $display("FAIL mid_after: %0d results first id=%0d, required 1 result id=0 p=%0d",
               id_q.size(), (id_q.size() > 0) ? id_q[0] : -1, tab_p[0]);
    end
  endtask

  initial begin
    ap_rst    = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    test_reset();
    test_single();
    test_boundaries();
    test_round_robin();
    test_fairness();
    test_backpressure();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
